// File: rtl/fifo_rd_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pack_pkg
// Description : Shared types and helpers for the FIFO read-side packer.
//               Lane order convention: lane0 occupies the LSBs of a wide word.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pack_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } pack_state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pack
// Description : Drains a fall-through FIFO and packs RATIO narrow words into
//               one wide valid/ready word; flush emits a partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_pack
  import fifo_rd_pack_pkg::*;
#(
  parameter  int DSIZE = 8,
  parameter  int RATIO = 4,
  localparam int CW    = clog2(RATIO + 1)
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] m_data,
  output logic [CW-1:0]          m_cnt,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int            c_aw   = DSIZE * (RATIO - 1);
  localparam logic [CW-1:0] c_last = CW'(RATIO - 1);
  localparam logic [CW-1:0] c_full = CW'(RATIO);

  pack_state_t     r_state;
  logic [CW-1:0]   r_cnt;
  logic [c_aw-1:0] r_acc;
  logic            w_out_free;
  logic            w_last;

  assign w_out_free = !m_valid || m_ready;
  assign w_last     = (r_cnt == c_last);

  // The last lane is only popped when the output register can take the word.
  assign rinc = rrst && !rempty && (r_state == ST_FILL) && (!w_last || w_out_free);

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_acc   <= '0;
      m_data  <= '0;
      m_cnt   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (r_state)
        ST_FILL: begin
          if (rinc && w_last) begin
            m_data  <= {rdata, r_acc};
            m_cnt   <= c_full;
            m_valid <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
          end else begin
            if (rinc) begin
              for (int i = 0; i < RATIO - 1; i++) begin
                if (r_cnt == CW'(i)) begin
                  r_acc[i*DSIZE +: DSIZE] <= rdata;
                end
              end
              r_cnt <= r_cnt + CW'(1);
            end
            // A same-cycle pop counts toward the lane total before the flush test.
            if (flush && (rinc || (r_cnt != '0))) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_out_free) begin
            m_data  <= {{DSIZE{1'b0}}, r_acc};
            m_cnt   <= r_cnt;
            m_valid <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_pack
// Description : Self-checking bench for fifo_rd_pack (DSIZE=8, RATIO=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_pack;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int CW    = 3;

  logic                   rclk;
  logic                   rrst;
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*RATIO-1:0] m_data;
  logic [CW-1:0]          m_cnt;
  logic                   m_valid;
  logic                   m_ready;

  fifo_rd_pack #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_cnt   (m_cnt),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks   = 0;
  int failures = 0;

  // FIFO contents and reference model state
  logic [7:0]  q[$];
  logic [7:0]  lanes[$];
  logic        mdl_pend;
  logic        mdl_valid;
  logic [31:0] mdl_data;
  logic [2:0]  mdl_cnt;
  logic        last_rinc;

  typedef struct {
    logic        fl;
    logic        rdy;
    logic        e_rinc;
    logic        e_valid;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv [0:14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_lanes();
    logic [31:0] d;
    d = '0;
    foreach (lanes[i]) d[8*i +: 8] = lanes[i];
    return d;
  endfunction

  task automatic model_reset();
    lanes.delete();
    mdl_pend  = 1'b0;
    mdl_valid = 1'b0;
    mdl_data  = '0;
    mdl_cnt   = '0;
  endtask

  // One clock: drive inputs at posedge+1, check rinc mid-cycle, check outputs at next posedge+1.
  task automatic cycle(input logic fl, input logic rdy);
    logic       exp_rinc;
    logic       out_free;
    logic       emit;
    logic [7:0] head;
    flush   = fl;
    m_ready = rdy;
    rempty  = (q.size() == 0);
    head    = (q.size() != 0) ? q[0] : 8'($urandom);
    rdata   = head;
    out_free = !mdl_valid || rdy;
    exp_rinc = !rempty && !mdl_pend && ((lanes.size() != RATIO - 1) || out_free);
    #3;
    chk("rinc", {31'b0, rinc}, {31'b0, exp_rinc});
    last_rinc = rinc;
    @(posedge rclk);
    #1;
    if (last_rinc && q.size() != 0) void'(q.pop_front());
    emit = 1'b0;
    if (!mdl_pend) begin
      if (exp_rinc) begin
        lanes.push_back(head);
        if (lanes.size() == RATIO) begin
          emit = 1'b1;
          mdl_data = pack_lanes();
          mdl_cnt  = 3'(RATIO);
          lanes.delete();
        end
      end
      if (fl && lanes.size() > 0) mdl_pend = 1'b1;
    end else if (out_free) begin
      emit = 1'b1;
      mdl_data = pack_lanes();
      mdl_cnt  = 3'(lanes.size());
      lanes.delete();
      mdl_pend = 1'b0;
    end
    if (emit) mdl_valid = 1'b1;
    else if (mdl_valid && rdy) mdl_valid = 1'b0;
    chk("m_valid", {31'b0, m_valid}, {31'b0, mdl_valid});
    if (mdl_valid) begin
      chk("m_data", m_data, mdl_data);
      chk("m_cnt", {29'b0, m_cnt}, {29'b0, mdl_cnt});
    end
    flush = 1'b0;
  endtask

  task automatic pulse_reset();
    rrst = 1'b0;
    #3;
    chk("rst_rinc", {31'b0, rinc}, 32'd0);
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_cnt", {29'b0, m_cnt}, 32'd0);
    @(posedge rclk);
    #1;
    rrst = 1'b1;
    model_reset();
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
    tv[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4};
    tv[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08070605, 3'd4};
    tv[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0};

    // Reset with a non-empty FIFO: nothing may be popped.
    rrst = 1'b0; rempty = 1'b0; rdata = 8'h5A; flush = 1'b0; m_ready = 1'b0;
    model_reset();
    #2;
    chk("reset_rinc", {31'b0, rinc}, 32'd0);
    chk("reset_valid", {31'b0, m_valid}, 32'd0);
    chk("reset_data", m_data, 32'd0);
    chk("reset_cnt", {29'b0, m_cnt}, 32'd0);
    repeat (2) @(posedge rclk);
    #1;
    chk("reset_rinc_clk", {31'b0, rinc}, 32'd0);
    rrst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (i == 0) q = '{8'h11, 8'h22, 8'h33, 8'h44};
      if (i == 5) q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      cycle(tv[i].fl, tv[i].rdy);
      chk($sformatf("tv%0d_rinc", i), {31'b0, last_rinc}, {31'b0, tv[i].e_rinc});
      chk($sformatf("tv%0d_valid", i), {31'b0, m_valid}, {31'b0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_data", i), m_data, tv[i].e_data);
        chk($sformatf("tv%0d_cnt", i), {29'b0, m_cnt}, {29'b0, tv[i].e_cnt});
      end
    end

    // Partial flush, then the next byte must land in lane0.
    q = '{8'hAA, 8'hBB};
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    q.push_back(8'hDD);
    cycle(1'b0, 1'b1);
    chk("flush_norinc", {31'b0, last_rinc}, 32'd0);
    chk("flush_data", m_data, 32'h0000BBAA);
    chk("flush_cnt", {29'b0, m_cnt}, 32'd2);
    cycle(1'b0, 1'b1);
    chk("after_flush_pop", {31'b0, last_rinc}, 32'd1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("lane0_data", m_data, 32'h000000DD);
    chk("lane0_cnt", {29'b0, m_cnt}, 32'd1);

    // Flush with nothing accumulated emits nothing.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("flush_empty_novalid", {31'b0, m_valid}, 32'd0);
    cycle(1'b0, 1'b1);
    chk("flush_empty_novalid2", {31'b0, m_valid}, 32'd0);

    // Flush on the emitting pop: one full word, no trailing partial word.
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    chk("flush4_data", m_data, 32'hA4A3A2A1);
    chk("flush4_cnt", {29'b0, m_cnt}, 32'd4);
    cycle(1'b0, 1'b1);
    chk("flush4_nopartial", {31'b0, m_valid}, 32'd0);
    cycle(1'b0, 1'b1);
    chk("flush4_nopartial2", {31'b0, m_valid}, 32'd0);

    // Reset mid-word discards the partial lanes.
    q = '{8'hE1, 8'hE2};
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    pulse_reset();
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    chk("post_reset_data", m_data, 32'hC4C3C2C1);
    chk("post_reset_cnt", {29'b0, m_cnt}, 32'd4);
    cycle(1'b0, 1'b1);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 1 && q.size() < 16) q.push_back(8'($urandom));
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
